phase_scheduler: RTL and testbench
==================================

PHASE_SCHEDULER -- requirements
Module: phase_scheduler

Interface
REQ-001 Parameter GREEN_MIN, default 4, minimum green cycles granted to a side.
REQ-002 Parameter GREEN_MAX, default 10, maximum green cycles when another side is waiting.
REQ-003 Parameter YELLOW_T, default 2, yellow cycles.
REQ-004 Parameter ALLRED_T, default 1, all-red clearance cycles.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  enables scheduling; low requests an orderly stop.
REQ-008 req  input  4  per-side demand, bit i is side i; may pulse or hold.
REQ-009 at_side  output  4  one-hot granted side; 0000 when no side is granted.
REQ-010 at_state  output  4  one-hot state: IDLE=0001, GREEN=0010, YELLOW=0100, ALLRED=1000.
REQ-011 R, Y, G  output  1 each  lamp for the granted side; exactly one is high at all times.

Function
REQ-012 All parameters SHALL be in the range 1..255, with GREEN_MIN <= GREEN_MAX; an 8-bit phase counter SHALL be used.
REQ-013 pending[3:0] SHALL set bit i when req[i]=1 and SHALL clear bit i on the cycle side i enters GREEN.
REQ-014 If req[i]=1 on the grant-entry cycle of side i, bit i SHALL remain clear (the grant consumes it).
REQ-015 In IDLE: at_side=0000, R=1; the FSM SHALL move to ALLRED on the first clock with start=1.
REQ-016 In ALLRED: R=1 and at_side=0000; after ALLRED_T cycles the FSM SHALL enter GREEN for the next pending side in round-robin order after the last-granted side.
REQ-017 If start=0 when ALLRED expires, the FSM SHALL go to IDLE.
REQ-018 If nothing is pending when ALLRED expires, the FSM SHALL remain in ALLRED until a bit is pending, then grant it on the next clock.
REQ-019 In GREEN: G=1 and at_side shows the granted side; the counter SHALL restart at 0 on entry.
REQ-020 GREEN SHALL exit to YELLOW when cnt >= GREEN_MIN-1, another side is pending, and req of the current side is 0.
REQ-021 GREEN SHALL exit to YELLOW when cnt = GREEN_MAX-1 and another side is pending, regardless of the current side's req.
REQ-022 GREEN SHALL exit to YELLOW when start=0 and cnt >= GREEN_MIN-1.
REQ-023 With no other side pending and start=1, GREEN SHALL rest indefinitely; the counter SHALL saturate at GREEN_MAX-1.
REQ-024 In YELLOW: Y=1 and at_side unchanged; after YELLOW_T cycles the FSM SHALL go to ALLRED.
REQ-025 The round-robin pointer SHALL update only on GREEN entry, and all four sides SHALL be serviced within four grants when all are pending.
REQ-026 Outputs SHALL be registered, so at_state, at_side and lamps change on the edge that changes state.

Reset
REQ-027 Reset low SHALL immediately force state=IDLE, at_side=0000, at_state=0001, R=1, Y=0, G=0, cnt=0, pending=0000, and last-granted=side 3 (so side 0 has first priority).
REQ-028 Asserting reset mid-phase SHALL abort the phase with no yellow or all-red sequence; release SHALL be synchronous to clk.

Structure
REQ-029 Package traffic_pkg SHALL hold the state encodings, side one-hot constants and default timing constants.
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter4 (inputs pending and last grant; output one-hot next grant; combinational).

Verification (GREEN_MIN=4, GREEN_MAX=10, YELLOW_T=2, ALLRED_T=1)
REQ-031 Scenario 1: reset then start=1, req=0001 pulse -> ALLRED for 1 cycle, GREEN side 0001 rests with G=1 and no yellow for at least 50 cycles.
REQ-032 Scenario 2: side 0 green, req[0]=0, pulse req[2] -> yellow after green cycle 4, 2 yellow cycles, 1 all-red cycle, GREEN at_side=0100.
REQ-033 Scenario 3: side 0 green with req[0] held, req[1] pending -> green lasts exactly 10 cycles, then 0010 is granted.
REQ-034 Scenario 4: req=1111 held -> grant order 0001, 0010, 0100, 1000, 0001, ...
REQ-035 Scenario 5: start=0 during green cycle 1 -> green holds until cycle 4, then yellow, then all-red, then IDLE (at_state=0001, R=1).
REQ-036 Scenario 6: reset low during YELLOW -> same cycle at_state=0001, R=1, at_side=0000, pending=0000.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared encodings and default timing for the four-side phase scheduler.
package traffic_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_GREEN  = 4'b0010,
    ST_YELLOW = 4'b0100,
    ST_ALLRED = 4'b1000
  } state_t;

  localparam logic [3:0] SIDE_NONE = 4'b0000;
  localparam logic [3:0] SIDE_0    = 4'b0001;
  localparam logic [3:0] SIDE_1    = 4'b0010;
  localparam logic [3:0] SIDE_2    = 4'b0100;
  localparam logic [3:0] SIDE_3    = 4'b1000;

  localparam int GREEN_MIN_DEF = 4;
  localparam int GREEN_MAX_DEF = 10;
  localparam int YELLOW_T_DEF  = 2;
  localparam int ALLRED_T_DEF  = 1;
  localparam int CNT_W         = 8;

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational round-robin pick: first pending side after the last-granted one.
module rr_arbiter4
  import traffic_pkg::*;
(
  input  logic [3:0] pending,
  input  logic [3:0] last_grant,
  output logic [3:0] grant
);

  logic [1:0] last_idx;
  logic [1:0] idx;
  logic       found;

  always_comb begin
    case (last_grant)
      SIDE_0:  last_idx = 2'd0;
      SIDE_1:  last_idx = 2'd1;
      SIDE_2:  last_idx = 2'd2;
      default: last_idx = 2'd3;
    endcase
  end

  always_comb begin
    grant = SIDE_NONE;
    found = 1'b0;
    idx   = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      idx = last_idx + 2'(i);
      if (!found && pending[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/phase_scheduler.sv
// Four-side green/yellow/all-red phase scheduler with round-robin grants.
//   state  | meaning
//   IDLE   | stopped, all lamps red, waiting for start
//   ALLRED | clearance interval, then grant next pending side
//   GREEN  | granted side has green, cnt measures phase length
//   YELLOW | granted side shows yellow before clearance
module phase_scheduler
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN = GREEN_MIN_DEF,
  parameter int GREEN_MAX = GREEN_MAX_DEF,
  parameter int YELLOW_T  = YELLOW_T_DEF,
  parameter int ALLRED_T  = ALLRED_T_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] req,
  output logic [3:0] at_side,
  output logic [3:0] at_state,
  output logic       R,
  output logic       Y,
  output logic       G
);

  localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] Y_LAST    = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALLRED_T - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       pending, pending_nxt;
  logic [3:0]       last_grant;
  logic [3:0]       grant;
  logic [3:0]       at_side_nxt;
  logic             r_nxt, y_nxt, g_nxt;
  logic             entry;
  logic             other_pending;
  logic             cur_req;
  logic             min_done, max_done;

  rr_arbiter4 u_arb (
    .pending    (pending),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign other_pending = |(pending & ~at_side);
  assign cur_req       = |(req & at_side);
  assign min_done      = (cnt >= GMIN_LAST);
  assign max_done      = (cnt >= GMAX_LAST);
  assign entry         = (state == ST_ALLRED) && (state_nxt == ST_GREEN);
  // A grant consumes the side's demand even if req is still high that cycle.
  assign pending_nxt   = (pending | req) & ~(entry ? grant : SIDE_NONE);
  assign at_state      = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      pending    <= SIDE_NONE;
      last_grant <= SIDE_3;
      at_side    <= SIDE_NONE;
      R          <= 1'b1;
      Y          <= 1'b0;
      G          <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pending <= pending_nxt;
      at_side <= at_side_nxt;
      R       <= r_nxt;
      Y       <= y_nxt;
      G       <= g_nxt;
      if (entry) last_grant <= grant;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (start) state_nxt = ST_ALLRED;
      end
      ST_ALLRED: begin
        if (cnt >= AR_LAST) begin
          cnt_nxt = '0;
          if (!start)        state_nxt = ST_IDLE;
          else if (|pending) state_nxt = ST_GREEN;
          else               cnt_nxt   = AR_LAST;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_GREEN: begin
        if ((min_done && other_pending && !cur_req) ||
            (max_done && other_pending) ||
            (!start && min_done)) begin
          state_nxt = ST_YELLOW;
          cnt_nxt   = '0;
        end else if (!max_done) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_YELLOW: begin
        if (cnt >= Y_LAST) begin
          state_nxt = ST_ALLRED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Lamps and side are computed from the upcoming state so they are registered.
  always_comb begin
    at_side_nxt = SIDE_NONE;
    r_nxt       = 1'b0;
    y_nxt       = 1'b0;
    g_nxt       = 1'b0;
    case (state_nxt)
      ST_GREEN: begin
        g_nxt       = 1'b1;
        at_side_nxt = entry ? grant : at_side;
      end
      ST_YELLOW: begin
        y_nxt       = 1'b1;
        at_side_nxt = at_side;
      end
      default: r_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_phase_scheduler.sv
// Directed scenario bench for phase_scheduler at default timing.
module tb_phase_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] at_side;
  logic [3:0] at_state;
  logic       R, Y, G;

  int tests = 0;
  int fails = 0;

  localparam logic [3:0] S_IDLE   = 4'b0001;
  localparam logic [3:0] S_GREEN  = 4'b0010;
  localparam logic [3:0] S_YELLOW = 4'b0100;
  localparam logic [3:0] S_ALLRED = 4'b1000;

  phase_scheduler #(
    .GREEN_MIN (4),
    .GREEN_MAX (10),
    .YELLOW_T  (2),
    .ALLRED_T  (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .req      (req),
    .at_side  (at_side),
    .at_state (at_state),
    .R        (R),
    .Y        (Y),
    .G        (G)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  // Counts consecutive negedges spent in st, bounded so a stuck FSM cannot hang.
  task automatic measure(input logic [3:0] st, output int n);
    n = 0;
    while (at_state === st && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic reset_start(input logic [3:0] r0, input logic [3:0] r1);
    tick();
    reset = 1'b0; start = 1'b0; req = 4'b0000;
    tick();
    reset = 1'b1;
    tick();
    start = 1'b1; req = r0;
    tick();
    req = r1;
    tick();
  endtask

  task automatic test_reset();
    tick();
    reset = 1'b0; start = 1'b0; req = 4'b0000;
    #1;
    tests++;
    if (at_state !== S_IDLE || at_side !== 4'b0000 || {R, Y, G} !== 3'b100) begin
      fails++;
      $display("FAIL reset_outputs: state=%b side=%b RYG=%b%b%b want 0001 0000 100",
               at_state, at_side, R, Y, G);
    end
    tests++;
    if (dut.pending !== 4'b0000) begin
      fails++;
      $display("FAIL reset_pending: got %b want 0000", dut.pending);
    end
    tick(); reset = 1'b1;
    repeat (3) tick();
    tests++;
    if (at_state !== S_IDLE || R !== 1'b1) begin
      fails++;
      $display("FAIL idle_hold: state=%b R=%b want 0001 1", at_state, R);
    end
  endtask

  task automatic test_rest();
    int bad;
    tick();
    reset = 1'b0; start = 1'b0; req = 4'b0000;
    tick(); reset = 1'b1;
    tick(); start = 1'b1; req = 4'b0001;
    tick(); req = 4'b0000;
    tests++;
    if (at_state !== S_ALLRED || at_side !== 4'b0000 || R !== 1'b1) begin
      fails++;
      $display("FAIL s1_allred: state=%b side=%b R=%b want 1000 0000 1", at_state, at_side, R);
    end
    tick();
    tests++;
    if (at_state !== S_GREEN || at_side !== 4'b0001 || {R, Y, G} !== 3'b001) begin
      fails++;
      $display("FAIL s1_green: state=%b side=%b RYG=%b%b%b want 0010 0001 001",
               at_state, at_side, R, Y, G);
    end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (at_state !== S_GREEN || G !== 1'b1 || Y !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL s1_rest: %0d cycles left green, want 0", bad);
    end
  endtask

  task automatic test_min_green();
    int n;
    reset_start(4'b0001, 4'b0000);
    req = 4'b0100;
    tick();
    req = 4'b0000;
    measure(S_GREEN, n);
    n = n + 1;
    tests++;
    if (n != 4) begin fails++; $display("FAIL s2_green_len: got %0d want 4", n); end
    tests++;
    if (at_state !== S_YELLOW || at_side !== 4'b0001 || {R, Y, G} !== 3'b010) begin
      fails++;
      $display("FAIL s2_yellow: state=%b side=%b RYG=%b%b%b want 0100 0001 010",
               at_state, at_side, R, Y, G);
    end
    measure(S_YELLOW, n);
    tests++;
    if (n != 2) begin fails++; $display("FAIL s2_yellow_len: got %0d want 2", n); end
    measure(S_ALLRED, n);
    tests++;
    if (n != 1) begin fails++; $display("FAIL s2_allred_len: got %0d want 1", n); end
    tests++;
    if (at_state !== S_GREEN || at_side !== 4'b0100) begin
      fails++;
      $display("FAIL s2_next_grant: state=%b side=%b want 0010 0100", at_state, at_side);
    end
  endtask

  task automatic test_max_green();
    int n;
    reset_start(4'b0011, 4'b0001);
    tests++;
    if (at_side !== 4'b0001) begin fails++; $display("FAIL s3_first: got %b want 0001", at_side); end
    measure(S_GREEN, n);
    tests++;
    if (n != 10) begin fails++; $display("FAIL s3_green_len: got %0d want 10", n); end
    measure(S_YELLOW, n);
    measure(S_ALLRED, n);
    tests++;
    if (at_state !== S_GREEN || at_side !== 4'b0010) begin
      fails++;
      $display("FAIL s3_next_grant: state=%b side=%b want 0010 0010", at_state, at_side);
    end
    req = 4'b0000;
  endtask

  task automatic test_back_to_back();
    logic [3:0] order [5];
    int n;
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;
    reset_start(4'b1111, 4'b1111);
    for (int k = 0; k < 5; k++) begin
      tests++;
      if (at_state !== S_GREEN || at_side !== order[k]) begin
        fails++;
        $display("FAIL s4_grant%0d: state=%b side=%b want 0010 %b", k, at_state, at_side, order[k]);
      end
      measure(S_GREEN, n);
      tests++;
      if (n != 10) begin fails++; $display("FAIL s4_len%0d: got %0d want 10", k, n); end
      measure(S_YELLOW, n);
      measure(S_ALLRED, n);
    end
    req = 4'b0000;
  endtask

  task automatic test_stop();
    int n;
    reset_start(4'b0001, 4'b0000);
    start = 1'b0;
    measure(S_GREEN, n);
    tests++;
    if (n != 4) begin fails++; $display("FAIL s5_green_len: got %0d want 4", n); end
    measure(S_YELLOW, n);
    tests++;
    if (n != 2) begin fails++; $display("FAIL s5_yellow_len: got %0d want 2", n); end
    measure(S_ALLRED, n);
    tests++;
    if (n != 1) begin fails++; $display("FAIL s5_allred_len: got %0d want 1", n); end
    tests++;
    if (at_state !== S_IDLE || R !== 1'b1 || at_side !== 4'b0000) begin
      fails++;
      $display("FAIL s5_idle: state=%b R=%b side=%b want 0001 1 0000", at_state, R, at_side);
    end
  endtask

  task automatic test_allred_wait();
    reset_start(4'b0000, 4'b0000);
    repeat (5) tick();
    tests++;
    if (at_state !== S_ALLRED || R !== 1'b1) begin
      fails++;
      $display("FAIL wait_allred: state=%b R=%b want 1000 1", at_state, R);
    end
    req = 4'b1000;
    tick();
    req = 4'b0000;
    tests++;
    if (at_state !== S_ALLRED) begin
      fails++;
      $display("FAIL wait_latency: state=%b want 1000", at_state);
    end
    tick();
    tests++;
    if (at_state !== S_GREEN || at_side !== 4'b1000) begin
      fails++;
      $display("FAIL wait_grant: state=%b side=%b want 0010 1000", at_state, at_side);
    end
  endtask

  task automatic test_reset_yellow();
    int n;
    reset_start(4'b0101, 4'b0000);
    measure(S_GREEN, n);
    tests++;
    if (at_state !== S_YELLOW) begin
      fails++;
      $display("FAIL s6_reach_yellow: state=%b want 0100", at_state);
    end
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if (at_state !== S_IDLE || R !== 1'b1 || Y !== 1'b0 || at_side !== 4'b0000) begin
      fails++;
      $display("FAIL s6_abort: state=%b RY=%b%b side=%b want 0001 10 0000", at_state, R, Y, at_side);
    end
    tests++;
    if (dut.pending !== 4'b0000) begin
      fails++;
      $display("FAIL s6_pending: got %b want 0000", dut.pending);
    end
    tick();
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rest();
    test_min_green();
    test_max_green();
    test_back_to_back();
    test_stop();
    test_allred_wait();
    test_reset_yellow();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
